perf_counter_unit: RTL and testbench

Synthesizable hardware performance monitor for the LEG pipelined core. It watches hazard-unit, controller and cache event strobes, and counts cycles, retired instructions, stalls, flushes and branch outcomes. Software reads the totals through a simple word-addressed register port on the peripheral bus. This lets profiling runs on silicon or FPGA report CPI and miss statistics without simulator probes.

---
 rtl/perf_counter_unit.sv | 121 ++++++++++++
 tb/tb_perf_counter_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// Performance monitor for the LEG pipeline: counts pipeline, hazard and cache events
// and exposes the totals through a word-addressed register port with one-cycle read latency.
module perf_counter_unit #(
    parameter int CW   = 32,
    parameter int NCNT = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrE,
    input  logic        StallE,
    input  logic        StallD,
    input  logic        StalluOp,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic        ldrStallD,
    input  logic        IStall,
    input  logic        DStall,
    input  logic        BranchE,
    input  logic        BranchTakenE,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
);

    localparam logic [31:0] ID_VALUE = 32'h5045_5246;

    logic            en;
    logic [NCNT-1:0] status;
    logic [CW-1:0]   cnt [NCNT];
    logic [31:0]     prev_instr;
    logic            prev_istall;
    logic            prev_dstall;
    logic            prev_ldr;

    logic            new_instr;
    logic            ctrl_wr;
    logic            status_wr;
    logic            clr;
    logic [NCNT-1:0] inc;
    logic [NCNT-1:0] wrap;
    logic [3:0]      cidx;
    logic [31:0]     rd_mux;

    always_comb begin
        new_instr = (InstrE != prev_instr) && (InstrE != 32'd0);
        ctrl_wr   = sel && we && (addr == 4'd0);
        status_wr = sel && we && (addr == 4'd1);
        clr       = ctrl_wr && wdata[1];

        inc     = '0;
        inc[0]  = 1'b1;
        inc[1]  = new_instr;
        inc[2]  = (InstrE == 32'd0) || StallE;
        inc[3]  = StallD && !StalluOp;
        inc[4]  = IStall && !prev_istall;
        inc[5]  = DStall && !prev_dstall;
        inc[6]  = DStall;
        inc[7]  = ldrStallD && !prev_ldr;
        inc[8]  = new_instr && BranchE;
        inc[9]  = new_instr && BranchTakenE;
        inc[10] = FlushD;
        inc[11] = FlushE;
        if (!en) inc = '0;

        // A clear suppresses the increment, so no wrap can be reported for that edge.
        wrap = '0;
        for (int i = 0; i < NCNT; i++) begin
            wrap[i] = inc[i] && (cnt[i] == {CW{1'b1}}) && !clr;
        end
    end

    always_comb begin
        rd_mux = '0;
        cidx   = addr - 4'd4;
        case (addr)
            4'd0:    rd_mux[0] = en;
            4'd1:    rd_mux[NCNT-1:0] = status;
            4'd2:    rd_mux = ID_VALUE;
            4'd3:    rd_mux = '0;
            default: rd_mux[CW-1:0] = cnt[cidx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en          <= 1'b0;
            status      <= '0;
            prev_instr  <= '0;
            prev_istall <= 1'b0;
            prev_dstall <= 1'b0;
            prev_ldr    <= 1'b0;
            rdata       <= '0;
            ready       <= 1'b0;
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
        end else begin
            // History flops track the inputs even while counting is disabled.
            prev_instr  <= InstrE;
            prev_istall <= IStall;
            prev_dstall <= DStall;
            prev_ldr    <= ldrStallD;

            if (ctrl_wr) en <= wdata[0];

            for (int i = 0; i < NCNT; i++) begin
                if (clr)         cnt[i] <= '0;
                else if (inc[i]) cnt[i] <= cnt[i] + 1'b1;
            end

            // A same-cycle wrap wins over write-1-to-clear.
            if (status_wr) status <= (status & ~wdata[NCNT-1:0]) | wrap;
            else           status <= status | wrap;

            ready <= sel;
            rdata <= (sel && !we) ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit (built with CW=16 so counter wrap is reachable).
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrE;
    logic        StallE, StallD, StalluOp, FlushD, FlushE, ldrStallD;
    logic        IStall, DStall, BranchE, BranchTakenE;
    logic        sel, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    int errors = 0;
    int checks = 0;

    perf_counter_unit #(.CW(16), .NCNT(12)) dut (
        .clk(clk), .reset(reset), .InstrE(InstrE),
        .StallE(StallE), .StallD(StallD), .StalluOp(StalluOp),
        .FlushD(FlushD), .FlushE(FlushE), .ldrStallD(ldrStallD),
        .IStall(IStall), .DStall(DStall),
        .BranchE(BranchE), .BranchTakenE(BranchTakenE),
        .sel(sel), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        step(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
        check("wr_ready", {31'd0, ready}, 32'd1);
        check("wr_rdata", rdata, 32'd0);
    endtask

    task automatic reg_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        sel = 1'b1; we = 1'b0; addr = a;
        step(1);
        sel = 1'b0;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check(tag, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; InstrE = '0;
        StallE = 0; StallD = 0; StalluOp = 0; FlushD = 0; FlushE = 0; ldrStallD = 0;
        IStall = 0; DStall = 0; BranchE = 0; BranchTakenE = 0;
        sel = 0; we = 0; addr = '0; wdata = '0;
        step(2);
        reset = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reg_read(4'd0, 32'd0, "rst_ctrl");
        reg_read(4'd4, 32'd0, "rst_c0");
        step(1);
        check("idle_ready", {31'd0, ready}, 32'd0);

        // Cycle/wasted counting with InstrE idle at zero.
        reg_write(4'd0, 32'd1);
        step(100);
        reg_read(4'd4, 32'd100, "c0_idle");
        reg_read(4'd6, 32'd101, "c2_idle");
        reg_read(4'd5, 32'd0, "c1_idle");
        reg_read(4'd2, 32'h5045_5246, "id");
        reg_read(4'd3, 32'd0, "reserved");

        // Instruction and branch counting.
        reg_write(4'd0, 32'd3);
        InstrE = 32'h1; step(1);
        InstrE = 32'h1; step(1);
        InstrE = 32'h2; BranchE = 1; BranchTakenE = 1; step(1);
        InstrE = 32'h0; BranchE = 0; BranchTakenE = 0; step(1);
        InstrE = 32'h3; step(1);
        InstrE = 32'h0;
        reg_read(4'd5, 32'd3, "c1_instr");
        reg_read(4'd12, 32'd1, "c8_branch");
        reg_read(4'd13, 32'd1, "c9_taken");

        // uOp cycles and load-use edges.
        reg_write(4'd0, 32'd3);
        StallD = 1; step(2);
        StalluOp = 1; step(1);
        StallD = 0; StalluOp = 0;
        ldrStallD = 1; step(2);
        ldrStallD = 0; step(1);
        ldrStallD = 1; step(1);
        ldrStallD = 0;
        reg_read(4'd7, 32'd2, "c3_uop");
        reg_read(4'd11, 32'd2, "c7_ldr");

        // D$ miss edges and stall cycles.
        reg_write(4'd0, 32'd3);
        DStall = 1; step(5);
        DStall = 0; step(2);
        DStall = 1; step(3);
        DStall = 0;
        reg_read(4'd9, 32'd2, "c5_dmiss");
        reg_read(4'd10, 32'd8, "c6_dstall");

        // An IStall edge seen while disabled is not counted after enabling.
        reg_write(4'd0, 32'd0);
        IStall = 1; step(2);
        reg_write(4'd0, 32'd3);
        step(3);
        IStall = 0; step(1);
        reg_read(4'd8, 32'd0, "c4_straddle");
        IStall = 1; step(1);
        IStall = 0;
        reg_read(4'd8, 32'd1, "c4_edge");

        // Flush counting, CLR beating a same-cycle increment, then freeze.
        FlushD = 1; FlushE = 1; step(3);
        FlushD = 0; FlushE = 0;
        reg_read(4'd14, 32'd3, "c10_flush");
        FlushD = 1; FlushE = 1;
        reg_write(4'd0, 32'd3);
        FlushD = 0; FlushE = 0;
        reg_read(4'd14, 32'd0, "c10_clr");
        reg_read(4'd15, 32'd0, "c11_clr");
        reg_read(4'd0, 32'd1, "ctrl_en");
        reg_write(4'd0, 32'd0);
        FlushD = 1; FlushE = 1; DStall = 1; InstrE = 32'h7;
        step(25);
        InstrE = 32'h8; DStall = 0;
        step(25);
        FlushD = 0; FlushE = 0; InstrE = 32'h0;
        reg_read(4'd14, 32'd0, "c10_frozen");
        reg_read(4'd15, 32'd0, "c11_frozen");
        reg_read(4'd4, 32'd4, "c0_frozen");

        // 16-bit wrap: C0 and C2 wrap on the same edge as a STATUS write-1-to-clear.
        reg_read(4'd1, 32'd0, "status_pre");
        reg_write(4'd0, 32'd3);
        step(65535);
        reg_write(4'd1, 32'd1);
        reg_read(4'd1, 32'd5, "status_wrap");
        reg_read(4'd4, 32'd1, "c0_wrapped");
        reg_write(4'd1, 32'd5);
        reg_read(4'd1, 32'd0, "status_w1c");

        // Mid-run reset.
        reg_write(4'd0, 32'd1);
        FlushD = 1; DStall = 1; InstrE = 32'h5;
        step(10);
        reset = 1'b1; step(1);
        reset = 1'b0;
        FlushD = 0; DStall = 0; InstrE = 32'h0;
        check("mrst_ready", {31'd0, ready}, 32'd0);
        check("mrst_rdata", rdata, 32'd0);
        reg_read(4'd4, 32'd0, "mrst_c0");
        reg_read(4'd10, 32'd0, "mrst_c6");
        reg_read(4'd14, 32'd0, "mrst_c10");
        reg_read(4'd0, 32'd0, "mrst_ctrl");
        reg_read(4'd1, 32'd0, "mrst_status");
        reg_read(4'd2, 32'h5045_5246, "mrst_id");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
